// File: rtl/input_cond_2b_if.sv
// Switch-side bundle of the two-bit input conditioner: raw switch bits in,
// debounced code with its update strobe and qualification flag out.
interface input_cond_2b_if;
    logic [1:0] raw;
    logic [1:0] code;
    logic       changed;
    logic       busy;

    // Source of the raw switch bits, consumer of the debounced code
    modport master (
        output raw,
        input  code,
        input  changed,
        input  busy
    );

    // The conditioner itself
    modport slave (
        input  raw,
        output code,
        output changed,
        output busy
    );
endinterface

// File: rtl/input_cond_2b.sv
// Two-bit input conditioner: two-flop synchronizer followed by a whole-symbol
// debouncer that publishes a code after DEBOUNCE_CYCLES identical samples.
module input_cond_2b #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic           clock,
    input  logic           init,
    input_cond_2b_if.slave io
);

    typedef enum logic {
        IDLE = 1'b0,
        QUAL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       code_q;
    logic [1:0]       code_d;
    logic [1:0]       cand_q;
    logic [1:0]       cand_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             changed_q;
    logic             changed_d;
    state_t           state_q;
    state_t           state_d;

    // Two-flop synchronizer for the asynchronous switch bits
    always_ff @(posedge clock or posedge init) begin
        if (init) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= io.raw;
            sync2_q <= sync1_q;
        end
    end

    // Debouncer state, qualified code and update strobe registers
    always_ff @(posedge clock or posedge init) begin
        if (init) begin
            state_q   <= IDLE;
            code_q    <= 2'b00;
            cand_q    <= 2'b00;
            cnt_q     <= CNT_ZERO;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
        end
    end

    // Next-state logic; the counter only runs while sync2 matches the candidate
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        changed_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q != code_q) begin
                    cand_d  = sync2_q;
                    cnt_d   = CNT_ONE;
                    state_d = QUAL;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            QUAL: begin
                if (sync2_q == cand_q) begin
                    if (cnt_q == CNT_LAST) begin
                        code_d    = cand_q;
                        changed_d = 1'b1;
                        cnt_d     = CNT_ZERO;
                        state_d   = IDLE;
                    end else begin
                        cnt_d     = cnt_q + CNT_ONE;
                    end
                end else if (sync2_q == code_q) begin
                    cnt_d   = CNT_ZERO;
                    state_d = IDLE;
                end else begin
                    // A different intermediate symbol restarts qualification
                    cand_d  = sync2_q;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = IDLE;
            end
        endcase
    end

    assign io.code    = code_q;
    assign io.changed = changed_q;
    assign io.busy    = (state_q == QUAL);

endmodule
